// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the two-master memory bus arbiter.
package mem_bus_pkg;

  // Arbiter FSM states
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Grant index values as carried on grant_id
  localparam logic GNT_M0 = 1'b0;
  localparam logic GNT_M1 = 1'b1;

  // Data word returned to a master whose access was forced complete
  localparam logic [31:0] DEF_TIMEOUT_RDATA = 32'hDEAD_BEEF;

  // Default bus geometry
  localparam int DEF_DATA_W = 32;
  localparam int DEF_STRB_W = DEF_DATA_W / 8;

  // One byte strobe per data byte
  function automatic int strb_width(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Native valid/ready memory bus (PicoRV32 style) with master and slave views.
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  import mem_bus_pkg::*;

  localparam int STRB_W = strb_width(DATA_W);

  logic              valid;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              ready;
  logic [DATA_W-1:0] rdata;

  // Side that issues requests
  modport master (
    output valid, addr, wdata, wstrb,
    input  ready, rdata
  );

  // Side that answers requests
  modport slave (
    input  valid, addr, wdata, wstrb,
    output ready, rdata
  );

endinterface

// File: rtl/mem_bus_arb_timer.sv
// Bus watchdog: counts BUSY cycles without a slave response.
module mem_bus_arb_timer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] count;

  // Count up while enabled, restart from zero whenever cleared
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 16'd1;
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master to one-slave arbiter with round-robin or fixed priority,
// grant held for the whole access and a watchdog that completes hung
// accesses with an error word.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int                ADDR_W         = 32,
  parameter int                DATA_W         = 32,
  parameter int                FIXED_PRIO     = 0,
  parameter int                TIMEOUT_CYCLES = 255,
  parameter logic [DATA_W-1:0] TIMEOUT_RDATA  = DEF_TIMEOUT_RDATA
) (
  input  logic clk,
  input  logic reset,
  mem_bus_arbiter_if.slave  m0,
  mem_bus_arbiter_if.slave  m1,
  mem_bus_arbiter_if.master s,
  output logic grant_id,
  output logic busy,
  output logic timeout_err
);

  localparam int STRB_W = strb_width(DATA_W);

  state_t            state;
  logic              last_grant;
  logic              pick;
  logic              in_busy;
  logic              expired;
  logic              done_ok;
  logic              done_tmo;
  logic              finish;
  logic              timer_clear;
  logic              timer_en;
  logic              g_valid;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_wdata;
  logic [STRB_W-1:0] g_wstrb;
  logic [DATA_W-1:0] resp_rdata;

  assign in_busy  = (state == ST_BUSY);
  assign done_ok  = in_busy && s.ready;
  assign done_tmo = in_busy && !s.ready && expired;
  assign finish   = done_ok || done_tmo;

  // Choose the next owner: a lone requester wins, ties go by priority mode
  always_comb begin
    pick = GNT_M0;
    if (m0.valid && m1.valid) begin
      pick = (FIXED_PRIO != 0) ? GNT_M0 : ~last_grant;
    end else if (m1.valid) begin
      pick = GNT_M1;
    end
  end

  // Route the granted master's request fields
  always_comb begin
    g_valid = m0.valid;
    g_addr  = m0.addr;
    g_wdata = m0.wdata;
    g_wstrb = m0.wstrb;
    if (grant_id == GNT_M1) begin
      g_valid = m1.valid;
      g_addr  = m1.addr;
      g_wdata = m1.wdata;
      g_wstrb = m1.wstrb;
    end
  end

  // Arbitration FSM: grant in IDLE, hold until completion, timeout or abandon
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      grant_id   <= GNT_M0;
      last_grant <= GNT_M1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (m0.valid || m1.valid) begin
            grant_id <= pick;
            state    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (finish) begin
            last_grant <= grant_id;
            state      <= ST_IDLE;
          end else if (!g_valid) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Watchdog runs only while an access is outstanding
  assign timer_clear = !in_busy;
  assign timer_en    = in_busy && g_valid && !finish;

  mem_bus_arb_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear),
    .enable (timer_en),
    .expired(expired)
  );

  // The expiry cycle withdraws the request so the slave cannot start late
  assign s.valid = in_busy && g_valid && !expired;
  assign s.addr  = in_busy ? g_addr  : '0;
  assign s.wdata = in_busy ? g_wdata : '0;
  assign s.wstrb = in_busy ? g_wstrb : '0;

  assign resp_rdata = s.ready ? s.rdata : (expired ? TIMEOUT_RDATA : '0);

  assign m0.ready = finish && (grant_id == GNT_M0);
  assign m1.ready = finish && (grant_id == GNT_M1);
  assign m0.rdata = (finish && (grant_id == GNT_M0)) ? resp_rdata : '0;
  assign m1.rdata = (finish && (grant_id == GNT_M1)) ? resp_rdata : '0;

  assign busy        = in_busy;
  assign timeout_err = done_tmo;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench: a round-robin and a fixed-priority arbiter share one
// set of inputs; a transaction-level reference model predicts both every
// cycle, and directed sequences cover the specific scenarios.
module tb_mem_bus_arbiter;

  localparam int          TMO      = 8;
  localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic        m0_valid = 1'b0, m1_valid = 1'b0;
  logic [31:0] m0_addr = '0, m1_addr = '0, m0_wdata = '0, m1_wdata = '0;
  logic [3:0]  m0_wstrb = '0, m1_wstrb = '0;
  logic        s_ready = 1'b0;
  logic [31:0] s_rdata = '0;

  logic [1:0]       o_s_valid, o_m0_ready, o_m1_ready, o_gid, o_busy, o_tmo;
  logic [1:0][31:0] o_s_addr, o_s_wdata, o_m0_rdata, o_m1_rdata;
  logic [1:0][3:0]  o_s_wstrb;

  int checks = 0;
  int errors = 0;
  bit mon_on = 1'b0;

  // Reference model: owner -1 means no access outstanding
  int mdl_owner[2];
  int mdl_age[2];
  int mdl_last[2];
  int mdl_gid[2];

  always #5 clk = ~clk;

  // Instance 0 is round-robin, instance 1 is fixed priority
  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    mem_bus_arbiter_if m0_bus ();
    mem_bus_arbiter_if m1_bus ();
    mem_bus_arbiter_if s_bus ();

    assign m0_bus.valid = m0_valid;
    assign m0_bus.addr  = m0_addr;
    assign m0_bus.wdata = m0_wdata;
    assign m0_bus.wstrb = m0_wstrb;
    assign m1_bus.valid = m1_valid;
    assign m1_bus.addr  = m1_addr;
    assign m1_bus.wdata = m1_wdata;
    assign m1_bus.wstrb = m1_wstrb;
    assign s_bus.ready  = s_ready;
    assign s_bus.rdata  = s_rdata;

    mem_bus_arbiter #(
      .FIXED_PRIO    (gi),
      .TIMEOUT_CYCLES(TMO)
    ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .m0         (m0_bus),
      .m1         (m1_bus),
      .s          (s_bus),
      .grant_id   (o_gid[gi]),
      .busy       (o_busy[gi]),
      .timeout_err(o_tmo[gi])
    );

    assign o_s_valid[gi]  = s_bus.valid;
    assign o_s_addr[gi]   = s_bus.addr;
    assign o_s_wdata[gi]  = s_bus.wdata;
    assign o_s_wstrb[gi]  = s_bus.wstrb;
    assign o_m0_ready[gi] = m0_bus.ready;
    assign o_m0_rdata[gi] = m0_bus.rdata;
    assign o_m1_ready[gi] = m1_bus.ready;
    assign o_m1_rdata[gi] = m1_bus.rdata;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic [31:0] a0, input logic [31:0] d0,
                               input logic [3:0] st0, input logic v1, input logic [31:0] a1,
                               input logic [31:0] d1, input logic [3:0] st1,
                               input logic sr, input logic [31:0] srd);
    m0_valid = v0; m0_addr = a0; m0_wdata = d0; m0_wstrb = st0;
    m1_valid = v1; m1_addr = a1; m1_wdata = d1; m1_wstrb = st1;
    s_ready  = sr; s_rdata = srd;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // Winner of an arbitration round from the request pattern and history
  function automatic int pickWinner(input int fixed, input int last, input bit v0, input bit v1);
    if (v0 && v1) return (fixed != 0) ? 0 : 1 - last;
    return v0 ? 0 : 1;
  endfunction

  // Advance the model one clock per instance
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        mdl_owner[i] <= -1;
        mdl_age[i]   <= 0;
        mdl_last[i]  <= 1;
        mdl_gid[i]   <= 0;
      end else if (mdl_owner[i] < 0) begin
        if (m0_valid || m1_valid) begin
          mdl_owner[i] <= pickWinner(i, mdl_last[i], m0_valid, m1_valid);
          mdl_gid[i]   <= pickWinner(i, mdl_last[i], m0_valid, m1_valid);
          mdl_age[i]   <= 0;
        end
      end else if (s_ready || mdl_age[i] == TMO - 1) begin
        mdl_last[i]  <= mdl_owner[i];
        mdl_owner[i] <= -1;
      end else if (!((mdl_owner[i] == 1) ? m1_valid : m0_valid)) begin
        mdl_owner[i] <= -1;
      end else begin
        mdl_age[i] <= mdl_age[i] + 1;
      end
    end
  end

  // Compare every output of both instances with the model mid-cycle
  always @(negedge clk) begin
    if (mon_on) begin
      for (int i = 0; i < 2; i++) begin
        logic        e_sv, e_r0, e_r1, e_tmo, gv, timed;
        logic [31:0] e_sa, e_sd, e_rd, e_d0, e_d1;
        logic [3:0]  e_ss;
        e_sv = 0; e_r0 = 0; e_r1 = 0; e_tmo = 0; e_sa = 0; e_sd = 0; e_ss = 0;
        e_d0 = 0; e_d1 = 0; e_rd = 0;
        if (mdl_owner[i] >= 0) begin
          gv    = (mdl_owner[i] == 1) ? m1_valid : m0_valid;
          timed = (mdl_age[i] == TMO - 1);
          e_sv  = gv && !timed;
          e_sa  = (mdl_owner[i] == 1) ? m1_addr  : m0_addr;
          e_sd  = (mdl_owner[i] == 1) ? m1_wdata : m0_wdata;
          e_ss  = (mdl_owner[i] == 1) ? m1_wstrb : m0_wstrb;
          e_rd  = s_ready ? s_rdata : (timed ? ERR_WORD : 32'h0);
          e_tmo = timed && !s_ready;
          if (mdl_owner[i] == 1) begin
            e_r1 = s_ready || timed; e_d1 = e_rd;
          end else begin
            e_r0 = s_ready || timed; e_d0 = e_rd;
          end
        end
        checkOutput($sformatf("mon%0d.s_valid", i), 32'(o_s_valid[i]), 32'(e_sv));
        checkOutput($sformatf("mon%0d.s_addr", i), o_s_addr[i], e_sa);
        checkOutput($sformatf("mon%0d.s_wdata", i), o_s_wdata[i], e_sd);
        checkOutput($sformatf("mon%0d.s_wstrb", i), 32'(o_s_wstrb[i]), 32'(e_ss));
        checkOutput($sformatf("mon%0d.m0_ready", i), 32'(o_m0_ready[i]), 32'(e_r0));
        checkOutput($sformatf("mon%0d.m0_rdata", i), o_m0_rdata[i], e_d0);
        checkOutput($sformatf("mon%0d.m1_ready", i), 32'(o_m1_ready[i]), 32'(e_r1));
        checkOutput($sformatf("mon%0d.m1_rdata", i), o_m1_rdata[i], e_d1);
        checkOutput($sformatf("mon%0d.grant_id", i), 32'(o_gid[i]), 32'(mdl_gid[i]));
        checkOutput($sformatf("mon%0d.busy", i), 32'(o_busy[i]), 32'(mdl_owner[i] >= 0));
        checkOutput($sformatf("mon%0d.timeout_err", i), 32'(o_tmo[i]), 32'(e_tmo));
      end
    end
  end

  // Both masters stream four writes into a slave that always answers at once
  task automatic runBackToBack(input int inst);
    int cnt[2];
    int n;
    int exp_m;
    int who;
    cnt[0] = 0; cnt[1] = 0; n = 0;
    doReset();
    applyStimulus(1, 32'h100, 32'hA000_0000, 4'hF, 1, 32'h200, 32'hB000_0000, 4'hF, 1, 32'h0);
    for (int c = 0; c < 40 && n < 8; c++) begin
      @(negedge clk);
      who = -1;
      if (o_m0_ready[inst]) who = 0;
      else if (o_m1_ready[inst]) who = 1;
      if (who >= 0) begin
        exp_m = (inst == 0) ? (n % 2) : ((n < 4) ? 0 : 1);
        checkOutput($sformatf("b2b%0d.grant%0d", inst, n), 32'(o_gid[inst]), 32'(exp_m));
        checkOutput($sformatf("b2b%0d.wdata%0d", inst, n), o_s_wdata[inst],
                    (exp_m == 1) ? m1_wdata : m0_wdata);
        n++;
      end
      step();
      if (who == 0) begin
        cnt[0]++; m0_wdata = m0_wdata + 1;
        if (cnt[0] == 4) m0_valid = 1'b0;
      end else if (who == 1) begin
        cnt[1]++; m1_wdata = m1_wdata + 1;
        if (cnt[1] == 4) m1_valid = 1'b0;
      end
    end
    checkOutput($sformatf("b2b%0d.count", inst), 32'(n), 32'd8);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    mdl_owner = '{-1, -1};
    mdl_age   = '{0, 0};
    mdl_last  = '{1, 1};
    mdl_gid   = '{0, 0};

    // Reset state
    step();
    mon_on = 1'b1;
    @(negedge clk);
    checkOutput("reset.grant_id", 32'(o_gid[0]), 32'd0);
    checkOutput("reset.busy", 32'(o_busy[0]), 32'd0);
    checkOutput("reset.s_valid", 32'(o_s_valid[0]), 32'd0);
    step();
    reset = 1'b0;

    // Single read by m0 with one slave wait cycle
    applyStimulus(1, 32'h10, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("rd.arb_s_valid", 32'(o_s_valid[0]), 32'd0);
    step();
    @(negedge clk);
    checkOutput("rd.s_valid", 32'(o_s_valid[0]), 32'd1);
    checkOutput("rd.s_addr", o_s_addr[0], 32'h10);
    checkOutput("rd.grant_id", 32'(o_gid[0]), 32'd0);
    step();
    applyStimulus(1, 32'h10, 0, 0, 0, 0, 0, 0, 1, 32'h1234_5678);
    @(negedge clk);
    checkOutput("rd.m0_ready", 32'(o_m0_ready[0]), 32'd1);
    checkOutput("rd.m0_rdata", o_m0_rdata[0], 32'h1234_5678);
    checkOutput("rd.m1_ready", 32'(o_m1_ready[0]), 32'd0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Back-to-back writes: round-robin, then fixed priority
    runBackToBack(0);
    runBackToBack(1);

    // Watchdog on an m1 read to a silent slave
    doReset();
    applyStimulus(0, 0, 0, 0, 1, 32'h40, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("tmo.idle_busy", 32'(o_busy[0]), 32'd0);
    step();
    for (int k = 1; k <= TMO; k++) begin
      @(negedge clk);
      if (k < TMO) begin
        checkOutput($sformatf("tmo.early_ready%0d", k), 32'(o_m1_ready[0]), 32'd0);
        checkOutput($sformatf("tmo.early_err%0d", k), 32'(o_tmo[0]), 32'd0);
      end else begin
        checkOutput("tmo.m1_ready", 32'(o_m1_ready[0]), 32'd1);
        checkOutput("tmo.m1_rdata", o_m1_rdata[0], ERR_WORD);
        checkOutput("tmo.err", 32'(o_tmo[0]), 32'd1);
        checkOutput("tmo.s_valid", 32'(o_s_valid[0]), 32'd0);
        checkOutput("tmo.m0_ready", 32'(o_m0_ready[0]), 32'd0);
      end
      step();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("tmo.after_busy", 32'(o_busy[0]), 32'd0);
    checkOutput("tmo.after_err", 32'(o_tmo[0]), 32'd0);
    step();

    // Complete an m0 access so the round-robin history points at m0
    applyStimulus(1, 32'h20, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    applyStimulus(1, 32'h20, 0, 0, 0, 0, 0, 0, 1, 32'h55);
    @(negedge clk);
    checkOutput("prime.m0_ready", 32'(o_m0_ready[0]), 32'd1);
    step();

    // Reset during the third BUSY cycle of an m0 access
    applyStimulus(1, 32'h30, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    @(negedge clk);
    checkOutput("rst.busy1_ready", 32'(o_m0_ready[0]), 32'd0);
    step();
    @(negedge clk);
    checkOutput("rst.busy2_ready", 32'(o_m0_ready[0]), 32'd0);
    step();
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rst.busy3_ready", 32'(o_m0_ready[0]), 32'd0);
    checkOutput("rst.busy3_busy", 32'(o_busy[0]), 32'd1);
    step();
    @(negedge clk);
    checkOutput("rst.after_busy", 32'(o_busy[0]), 32'd0);
    checkOutput("rst.after_s_valid", 32'(o_s_valid[0]), 32'd0);
    checkOutput("rst.after_grant", 32'(o_gid[0]), 32'd0);
    checkOutput("rst.after_ready", 32'(o_m0_ready[0]), 32'd0);
    step();
    reset = 1'b0;
    applyStimulus(1, 32'h300, 0, 0, 1, 32'h400, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("rst.tie_arb_busy", 32'(o_busy[0]), 32'd0);
    step();
    @(negedge clk);
    checkOutput("rst.tie_grant", 32'(o_gid[0]), 32'd0);
    checkOutput("rst.tie_addr", o_s_addr[0], 32'h300);
    step();
    applyStimulus(1, 32'h300, 0, 0, 1, 32'h400, 0, 0, 1, 32'h77);
    @(negedge clk);
    checkOutput("rst.tie_ready", 32'(o_m0_ready[0]), 32'd1);
    step();

    // m0 abandons its access; a late slave ready must be ignored
    doReset();
    applyStimulus(1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    applyStimulus(1, 32'h100, 0, 0, 1, 32'h200, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("drop.grant", 32'(o_gid[0]), 32'd0);
    step();
    applyStimulus(0, 0, 0, 0, 1, 32'h200, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("drop.no_ready", 32'(o_m0_ready[0]), 32'd0);
    step();
    applyStimulus(0, 0, 0, 0, 1, 32'h200, 0, 0, 1, 32'h99);
    @(negedge clk);
    checkOutput("drop.idle_busy", 32'(o_busy[0]), 32'd0);
    checkOutput("drop.idle_m0_ready", 32'(o_m0_ready[0]), 32'd0);
    checkOutput("drop.idle_m1_ready", 32'(o_m1_ready[0]), 32'd0);
    step();
    @(negedge clk);
    checkOutput("drop.m1_grant", 32'(o_gid[0]), 32'd1);
    checkOutput("drop.m1_ready", 32'(o_m1_ready[0]), 32'd1);
    checkOutput("drop.m1_rdata", o_m1_rdata[0], 32'h99);
    step();

    // Randomized traffic, both instances checked against the model
    doReset();
    for (int c = 0; c < 3000; c++) begin
      applyStimulus($urandom_range(0, 3) != 0, $urandom, $urandom, 4'($urandom),
                    $urandom_range(0, 3) != 0, $urandom, $urandom, 4'($urandom),
                    $urandom_range(0, 9) < 3, $urandom);
      reset = ($urandom_range(0, 99) == 0);
      step();
    end
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    mon_on = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
